sram_l1_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of `sram_wrap_l1`. It accepts read and write requests over valid/ready handshakes and drives the SRAM's active-low `csb`/`we` protocol. It holds `csb` for the required write time, or waits for `data_ready` on reads, then returns a one-cycle response to the owning requester. It sits between the L1 fetch/load-store ports (requester 0 and requester 1) and the single SRAM macro wrapper.

---
 rtl/sram_l1_arbiter_pkg.sv | 20 ++
 rtl/sram_l1_arbiter_rr_arbiter.sv | 18 +
 rtl/sram_l1_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_sram_l1_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_l1_arbiter_pkg.sv
// Shared types and default widths for the L1 SRAM arbiter slice.
package sram_l1_arb_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 9;
   localparam int unsigned DEF_DATA_WIDTH     = 33;
   localparam int unsigned DEF_NUM_WMASKS     = 4;
   localparam int unsigned DEF_WR_CYCLES      = 2;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Requester index: 0 = fetch port, 1 = load/store port.
   typedef logic req_id_t;

endpackage

// File: rtl/sram_l1_arbiter_rr_arbiter.sv
// Two-way round-robin grant from the request valids and the last-served id.
module sram_l1_rr_arbiter
   import sram_l1_arb_pkg::*;
(
   input  logic    valid0,
   input  logic    valid1,
   input  req_id_t last,
   output logic    gnt0,
   output logic    gnt1
);

   // A lone requester wins; on a tie the requester not served last wins.
   always_comb begin
      gnt0 = valid0 & (~valid1 | (last == 1'b1));
      gnt1 = valid1 & (~valid0 | (last == 1'b0));
   end

endmodule

// File: rtl/sram_l1_arbiter.sv
// Round-robin arbiter and csb/we sequencer in front of sram_wrap_l1.
// Optional read watchdog: define SRAM_ARB_TIMEOUT_EN.
module sram_l1_arbiter
   import sram_l1_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned NUM_WMASKS     = DEF_NUM_WMASKS,
   parameter int unsigned WR_CYCLES      = DEF_WR_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-2:0] req0_wdata,
   input  logic [NUM_WMASKS-1:0] req0_wmask,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-2:0] req1_wdata,
   input  logic [NUM_WMASKS-1:0] req1_wmask,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-2:0] rsp0_rdata,
   output logic                  rsp0_err,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-2:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic                  sram_csb,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-2:0] sram_wdata,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   input  logic [DATA_WIDTH-2:0] sram_rdata,
   input  logic                  sram_data_ready
);

   localparam int unsigned DW  = DATA_WIDTH - 1;
   localparam int unsigned WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam logic [WCW-1:0] WR_CNT_INIT = WCW'(WR_CYCLES - 1);

   arb_state_e            state_q, state_d;
   req_id_t               owner_q, owner_d;
   req_id_t               last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
   logic                  csb_q, csb_d;
   logic                  swe_q, swe_d;
   logic [WCW-1:0]        wr_cnt_q, wr_cnt_d;
   logic                  rsp0_valid_q, rsp0_valid_d;
   logic                  rsp1_valid_q, rsp1_valid_d;
   logic [DW-1:0]         rsp0_rdata_q, rsp0_rdata_d;
   logic [DW-1:0]         rsp1_rdata_q, rsp1_rdata_d;
   logic                  gnt0, gnt1;
   logic                  timed_out;

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
   logic [TCW-1:0] to_cnt_q, to_cnt_d;
   logic           rsp0_err_q, rsp0_err_d;
   logic           rsp1_err_q, rsp1_err_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   sram_l1_rr_arbiter u_rr (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last_q),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   // Readies are only offered while idle and out of reset.
   always_comb begin
      req0_ready = gnt0 & (state_q == IDLE) & rst_n;
      req1_ready = gnt1 & (state_q == IDLE) & rst_n;
   end

   // Next-state, request capture, read-data capture and response pulse.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      wr_cnt_d     = wr_cnt_q;
      rsp0_rdata_d = rsp0_rdata_q;
      rsp1_rdata_d = rsp1_rdata_q;
      timed_out    = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               owner_d  = req1_ready;
               last_d   = req1_ready;
               addr_d   = req1_ready ? req1_addr  : req0_addr;
               wdata_d  = req1_ready ? req1_wdata : req0_wdata;
               wmask_d  = req1_ready ? req1_wmask : req0_wmask;
               wr_cnt_d = WR_CNT_INIT;
`ifdef SRAM_ARB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
               state_d  = (req1_ready ? req1_we : req0_we) ? WRITE : READ;
            end
         end
         WRITE: begin
            if (wr_cnt_q == '0) state_d = RESP;
            else                wr_cnt_d = wr_cnt_q - WCW'(1);
         end
         READ: begin
            if (sram_data_ready) begin
               state_d = RESP;
               if (owner_q == 1'b0) rsp0_rdata_d = sram_rdata;
               else                 rsp1_rdata_d = sram_rdata;
            end
`ifdef SRAM_ARB_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               state_d   = RESP;
               timed_out = 1'b1;
               if (owner_q == 1'b0) rsp0_rdata_d = '0;
               else                 rsp1_rdata_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + TCW'(1);
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // SRAM strobes and response pulses are registered from the next state.
      csb_d        = ~((state_d == WRITE) || (state_d == READ));
      swe_d        = ~(state_d == WRITE);
      rsp0_valid_d = (state_d == RESP) && (owner_d == 1'b0);
      rsp1_valid_d = (state_d == RESP) && (owner_d == 1'b1);
`ifdef SRAM_ARB_TIMEOUT_EN
      rsp0_err_d   = rsp0_valid_d & timed_out;
      rsp1_err_d   = rsp1_valid_d & timed_out;
`endif
   end

   // All state and outputs; reset forces deselect immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         csb_q        <= 1'b1;
         swe_q        <= 1'b1;
         wr_cnt_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
         to_cnt_q     <= '0;
         rsp0_err_q   <= 1'b0;
         rsp1_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         csb_q        <= csb_d;
         swe_q        <= swe_d;
         wr_cnt_q     <= wr_cnt_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
`ifdef SRAM_ARB_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_err_q   <= rsp1_err_d;
`endif
      end
   end

   assign sram_csb   = csb_q;
   assign sram_we    = swe_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign sram_wmask = wmask_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
   assign rsp0_err   = rsp0_err_q;
   assign rsp1_err   = rsp1_err_q;
`else
   assign rsp0_err   = 1'b0;
   assign rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_l1_arbiter.sv
// Directed bench for sram_l1_arbiter with a small behavioural SRAM.
module tb_sram_l1_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic        req0_we = 1'b0, req1_we = 1'b0;
   logic [8:0]  req0_addr = '0, req1_addr = '0;
   logic [31:0] req0_wdata = '0, req1_wdata = '0;
   logic [3:0]  req0_wmask = '0, req1_wmask = '0;
   logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        sram_csb, sram_we;
   logic [8:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_wmask;
   logic [31:0] sram_rdata;
   logic        sram_data_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   bit [31:0] mem [512];
   bit        written [512];

   always #5 clk = ~clk;

   sram_l1_arbiter #(
      .ADDR_WIDTH     (9),
      .DATA_WIDTH     (33),
      .NUM_WMASKS     (4),
      .WR_CYCLES      (2),
      .TIMEOUT_CYCLES (80)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_we         (req0_we),
      .req0_addr       (req0_addr),
      .req0_wdata      (req0_wdata),
      .req0_wmask      (req0_wmask),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_we         (req1_we),
      .req1_addr       (req1_addr),
      .req1_wdata      (req1_wdata),
      .req1_wmask      (req1_wmask),
      .rsp0_valid      (rsp0_valid),
      .rsp0_rdata      (rsp0_rdata),
      .rsp0_err        (rsp0_err),
      .rsp1_valid      (rsp1_valid),
      .rsp1_rdata      (rsp1_rdata),
      .rsp1_err        (rsp1_err),
      .sram_csb        (sram_csb),
      .sram_we         (sram_we),
      .sram_addr       (sram_addr),
      .sram_wdata      (sram_wdata),
      .sram_wmask      (sram_wmask),
      .sram_rdata      (sram_rdata),
      .sram_data_ready (sram_data_ready)
   );

   // SRAM model: byte-masked write while selected; unwritten words read a pattern.
   always @(posedge clk) begin
      if (!sram_csb && !sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         written[sram_addr] <= 1'b1;
      end
   end

   always_comb sram_rdata = written[sram_addr] ? mem[sram_addr] : (32'hA5A5_0000 | 32'(sram_addr));

   task automatic test_reset();
      #1 rst_n = 1'b0;
      req0_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (sram_csb !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 9'd0 || sram_wdata !== 32'd0 || sram_wmask !== 4'd0) begin
         failures++;
         $display("FAIL reset_sram: got csb=%b we=%b addr=%0d wdata=%0d wmask=%b, want 1 1 0 0 0000", sram_csb, sram_we, sram_addr, sram_wdata, sram_wmask);
      end
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_err !== 1'b0 || rsp1_err !== 1'b0 || rsp0_rdata !== 32'd0 || rsp1_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_rsp: got v=%b%b err=%b%b rdata=%h/%h, want all zero", rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
      end
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      @(negedge clk);
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'd48; req0_wdata = 32'd77; req0_wmask = 4'b1111;
      sram_data_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL wr_ready: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         checks++;
         if (sram_csb !== 1'b0 || sram_we !== 1'b0 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_strobe_c%0d: got csb=%b we=%b rsp0_valid=%b, want 0 0 0", c, sram_csb, sram_we, rsp0_valid);
         end
         if (c == 1) begin
            checks++;
            if (sram_addr !== 9'd48 || sram_wdata !== 32'd77 || sram_wmask !== 4'b1111) begin
               failures++;
               $display("FAIL wr_payload: got addr=%0d wdata=%0d wmask=%b, want 48 77 1111", sram_addr, sram_wdata, sram_wmask);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (sram_csb !== 1'b1 || sram_we !== 1'b1 || rsp0_valid !== 1'b1 || rsp0_err !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'd0) begin
         failures++;
         $display("FAIL wr_resp: got csb=%b we=%b v0=%b err0=%b v1=%b rdata0=%0d, want 1 1 1 0 0 0", sram_csb, sram_we, rsp0_valid, rsp0_err, rsp1_valid, rsp0_rdata);
      end
      @(negedge clk);
      sram_data_ready = 1'b0;
      checks++;
      if (rsp0_valid !== 1'b0 || sram_csb !== 1'b1) begin
         failures++;
         $display("FAIL wr_pulse_end: got v0=%b csb=%b, want 0 1", rsp0_valid, sram_csb);
      end
   endtask

   task automatic test_read();
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd48;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL rd_ready: got r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (sram_csb !== 1'b0 || sram_we !== 1'b1 || sram_addr !== 9'd48 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait_c%0d: got csb=%b we=%b addr=%0d v1=%b, want 0 1 48 0", c, sram_csb, sram_we, sram_addr, rsp1_valid);
         end
         @(negedge clk);
      end
      sram_data_ready = 1'b1;
      @(negedge clk);
      sram_data_ready = 1'b0;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'd77 || rsp1_err !== 1'b0 || rsp0_valid !== 1'b0 || sram_csb !== 1'b1) begin
         failures++;
         $display("FAIL rd_resp: got v1=%b rdata1=%0d err1=%b v0=%b csb=%b, want 1 77 0 0 1", rsp1_valid, rsp1_rdata, rsp1_err, rsp0_valid, sram_csb);
      end
      @(negedge clk);
      checks++;
      if (rsp1_valid !== 1'b0 || rsp1_rdata !== 32'd77 || rsp0_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rd_hold: got v1=%b rdata1=%0d rdata0=%0d, want 0 77 0", rsp1_valid, rsp1_rdata, rsp0_rdata);
      end
   endtask

   task automatic test_round_robin();
      bit exp_id;
      bit seen;
      int n;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd1;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd2;
      exp_id = 1'b0;
      for (int r = 0; r < 4; r++) begin
         n = 0;
         #1;
         while (!req0_ready && !req1_ready && n < 20) begin
            @(negedge clk); #1; n++;
         end
         checks++;
         if (req0_ready !== (exp_id == 1'b0) || req1_ready !== (exp_id == 1'b1)) begin
            failures++;
            $display("FAIL rr_grant_%0d: got r0=%b r1=%b, want requester %0d only", r, req0_ready, req1_ready, exp_id);
         end
         @(posedge clk);
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            sram_data_ready = (sram_csb == 1'b0 && sram_we == 1'b1);
            if (rsp0_valid || rsp1_valid) begin
               seen = 1'b1;
               checks++;
               if (exp_id == 1'b0 && (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'hA5A5_0001)) begin
                  failures++;
                  $display("FAIL rr_rsp_%0d: got v0=%b v1=%b rdata0=%h, want 1 0 a5a50001", r, rsp0_valid, rsp1_valid, rsp0_rdata);
               end
               if (exp_id == 1'b1 && (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== 32'hA5A5_0002)) begin
                  failures++;
                  $display("FAIL rr_rsp_%0d: got v0=%b v1=%b rdata1=%h, want 0 1 a5a50002", r, rsp0_valid, rsp1_valid, rsp1_rdata);
               end
            end
         end
         if (!seen) begin
            checks++; failures++;
            $display("FAIL rr_rsp_%0d: got no response within 20 cycles, want one", r);
         end
         exp_id = ~exp_id;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; sram_data_ready = 1'b0;
   endtask

`ifdef SRAM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      @(negedge clk);
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd2;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL to_ready: got r0=%b, want 1", req0_ready);
      end
      @(posedge clk);
      req0_valid = 1'b0;
      bad = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (sram_csb !== 1'b0 || rsp0_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL to_wait: got %0d cycles with csb high or early rsp, want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'd0 || sram_csb !== 1'b1 || rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_resp: got v0=%b err0=%b rdata0=%h csb=%b v1=%b, want 1 1 0 1 0", rsp0_valid, rsp0_err, rsp0_rdata, sram_csb, rsp1_valid);
      end
   endtask
`endif

   task automatic test_reset_mid_read();
      int bad;
      @(negedge clk);
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd5;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL rm_ready: got r0=%b, want 1", req0_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      checks++;
      if (sram_csb !== 1'b0) begin
         failures++;
         $display("FAIL rm_inflight: got csb=%b, want 0", sram_csb);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (sram_csb !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 9'd0 || rsp0_valid !== 1'b0 || rsp0_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rm_async: got csb=%b we=%b addr=%0d v0=%b rdata0=%h, want 1 1 0 0 0", sram_csb, sram_we, sram_addr, rsp0_valid, rsp0_rdata);
      end
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || sram_csb !== 1'b1) bad++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || sram_csb !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rm_dropped: got %0d cycles with a response or csb low, want 0", bad);
      end
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd48;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL rm_fresh_ready: got r0=%b, want 1", req0_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      sram_data_ready = 1'b1;
      @(negedge clk);
      sram_data_ready = 1'b0;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'd77 || rsp0_err !== 1'b0 || rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL rm_fresh_resp: got v0=%b rdata0=%0d err0=%b v1=%b, want 1 77 0 0", rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
`ifdef SRAM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at 300000, want finished");
      $fatal(1);
   end

endmodule
